// File: rtl/mining_job_scheduler.sv
// mining_job_scheduler
// Sequences the mining pipeline for one job at a time. A job (opcode, header,
// nonce range) is accepted over a valid/ready handshake. Each nonce is issued
// with a one-cycle valid_opcode strobe and then gets RESULT_LAT cycles in which
// match_found is credited to it. The job ends on a match, on exhaustion of the
// range, or on abort, and a one-cycle done pulse is raised.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   job_valid / job_ready             job handshake (ready only in IDLE)
//   job_opcode, job_header            job payload
//   job_nonce_start, job_nonce_count  nonce range (count 0 = 2^NONCE_W)
//   abort                             cancel current job
//   opcode, operand, valid_opcode,
//   start_mine                        pipeline drive
//   match_found                       pipeline result
//   busy, done, found, found_nonce,
//   attempts                          job status
module mining_job_scheduler #(
    parameter int unsigned NONCE_W    = 16,
    parameter int unsigned RESULT_LAT = 8,
    parameter int unsigned CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [7:0]         job_opcode,
    input  logic [80:0]        job_header,
    input  logic [NONCE_W-1:0] job_nonce_start,
    input  logic [NONCE_W-1:0] job_nonce_count,
    input  logic               abort,
    output logic [7:0]         opcode,
    output logic [80:0]        operand,
    output logic               valid_opcode,
    output logic               start_mine,
    input  logic               match_found,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [NONCE_W-1:0] found_nonce,
    output logic [CNT_W-1:0]   attempts
);

    localparam int unsigned HDR_W = 81;
    localparam int unsigned HI_W  = HDR_W - NONCE_W;
    localparam int unsigned REM_W = NONCE_W + 1;
    localparam int unsigned WIN_W = $clog2(RESULT_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_accept;
    logic               w_match;
    logic               w_nonce_inc;

    logic [7:0]         r_opcode;
    logic [HI_W-1:0]    r_hdr_hi;
    logic [NONCE_W-1:0] r_nonce;
    logic [REM_W-1:0]   r_remaining;
    logic [WIN_W-1:0]   r_win;
    logic [CNT_W-1:0]   r_attempts;
    logic               r_found;
    logic [NONCE_W-1:0] r_found_nonce;
    logic               r_job_ready;
    logic               r_busy;
    logic               r_valid_opcode;
    logic               r_start_mine;
    logic               r_done;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next state; abort outranks match, match outranks window expiry
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_match      = 1'b0;
        w_nonce_inc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (job_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (abort) w_next_state = S_DONE;
                else       w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (abort) begin
                    w_next_state = S_DONE;
                end else if (match_found) begin
                    w_match      = 1'b1;
                    w_next_state = S_DONE;
                end else if (r_win == WIN_W'(1)) begin
                    if (r_remaining == '0) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_nonce_inc  = 1'b1;
                        w_next_state = S_ISSUE;
                    end
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Status/strobe outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_job_ready    <= 1'b1;
            r_busy         <= 1'b0;
            r_valid_opcode <= 1'b0;
            r_start_mine   <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_job_ready    <= (w_next_state == S_IDLE);
            r_busy         <= (w_next_state != S_IDLE);
            r_valid_opcode <= (w_next_state == S_ISSUE);
            r_start_mine   <= (w_next_state == S_ISSUE) || (w_next_state == S_WAIT);
            r_done         <= (w_next_state == S_DONE);
        end
    end

    // Job datapath: operand fields, range bookkeeping, result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opcode      <= '0;
            r_hdr_hi      <= '0;
            r_nonce       <= '0;
            r_remaining   <= '0;
            r_win         <= '0;
            r_attempts    <= '0;
            r_found       <= 1'b0;
            r_found_nonce <= '0;
        end else begin
            if (w_accept) begin
                r_opcode   <= job_opcode;
                r_hdr_hi   <= job_header[HDR_W-1:NONCE_W];
                r_nonce    <= job_nonce_start;
                // count of zero means the full 2^NONCE_W range
                r_remaining <= (job_nonce_count == '0) ? {1'b1, {NONCE_W{1'b0}}}
                                                       : {1'b0, job_nonce_count};
                r_attempts <= '0;
                r_found    <= 1'b0;
            end
            if (r_state == S_ISSUE) begin
                r_win       <= WIN_W'(RESULT_LAT);
                r_remaining <= r_remaining - REM_W'(1);
                if (r_attempts != '1) r_attempts <= r_attempts + CNT_W'(1);
            end else if (r_state == S_WAIT) begin
                r_win <= r_win - WIN_W'(1);
            end
            if (w_nonce_inc) r_nonce <= r_nonce + NONCE_W'(1);
            if (w_match) begin
                r_found       <= 1'b1;
                r_found_nonce <= r_nonce;
            end
        end
    end

    assign job_ready    = r_job_ready;
    assign busy         = r_busy;
    assign valid_opcode = r_valid_opcode;
    assign start_mine   = r_start_mine;
    assign done         = r_done;
    assign opcode       = r_opcode;
    assign operand      = {r_hdr_hi, r_nonce};
    assign found        = r_found;
    assign found_nonce  = r_found_nonce;
    assign attempts     = r_attempts;

endmodule

// File: tb/tb_mining_job_scheduler.sv
// Directed testbench for mining_job_scheduler (NONCE_W=16, RESULT_LAT=8).
module tb_mining_job_scheduler;

    localparam int unsigned NW  = 16;
    localparam int unsigned LAT = 8;
    localparam int unsigned CW  = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          job_valid;
    logic          job_ready;
    logic [7:0]    job_opcode;
    logic [80:0]   job_header;
    logic [NW-1:0] job_nonce_start;
    logic [NW-1:0] job_nonce_count;
    logic          abort;
    logic [7:0]    opcode;
    logic [80:0]   operand;
    logic          valid_opcode;
    logic          start_mine;
    logic          match_found;
    logic          busy;
    logic          done;
    logic          found;
    logic [NW-1:0] found_nonce;
    logic [CW-1:0] attempts;

    int checks = 0;
    int errors = 0;
    logic [NW-1:0] nlog [0:15];
    int nstrobes;
    int ncycles;
    logic [80:0] hdr;

    mining_job_scheduler #(.NONCE_W(NW), .RESULT_LAT(LAT), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .job_valid       (job_valid),
        .job_ready       (job_ready),
        .job_opcode      (job_opcode),
        .job_header      (job_header),
        .job_nonce_start (job_nonce_start),
        .job_nonce_count (job_nonce_count),
        .abort           (abort),
        .opcode          (opcode),
        .operand         (operand),
        .valid_opcode    (valid_opcode),
        .start_mine      (start_mine),
        .match_found     (match_found),
        .busy            (busy),
        .done            (done),
        .found           (found),
        .found_nonce     (found_nonce),
        .attempts        (attempts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [80:0] got, input logic [80:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] op, input logic [NW-1:0] start, input logic [NW-1:0] cnt);
        job_opcode      = op;
        job_header      = hdr;
        job_nonce_start = start;
        job_nonce_count = cnt;
        job_valid       = 1'b1;
    endtask

    // Runs from the current cycle until done (bounded), logging issued nonces
    task automatic run_to_done(input int max_cyc);
        nstrobes = 0;
        ncycles  = 0;
        while (!done && ncycles < max_cyc) begin
            if (valid_opcode) begin
                if (nstrobes < 16) nlog[nstrobes] = operand[NW-1:0];
                nstrobes++;
            end
            step();
            ncycles++;
        end
        chk("done_seen", 81'(done), 81'(1));
    endtask

    initial begin
        int n;
        logic got_done;
        hdr             = 81'h1_DEAD_BEEF_CAFE_F00D_1234;
        rst_n           = 1'b0;
        job_valid       = 1'b0;
        job_opcode      = '0;
        job_header      = '0;
        job_nonce_start = '0;
        job_nonce_count = '0;
        abort           = 1'b0;
        match_found     = 1'b0;
        #12;
        chk("rst_ready", 81'(job_ready), 81'(1));
        chk("rst_busy",  81'(busy), 81'(0));
        chk("rst_oper",  operand, 81'(0));
        chk("rst_att",   81'(attempts), 81'(0));
        rst_n = 1'b1;
        step();

        // Single match on the second nonce
        offer(8'h10, 16'd5, 16'd4);
        step();
        job_valid = 1'b0;
        chk("m_vop1",   81'(valid_opcode), 81'(1));
        chk("m_smine",  81'(start_mine), 81'(1));
        chk("m_ready",  81'(job_ready), 81'(0));
        chk("m_opc",    81'(opcode), 81'h10);
        chk("m_oper1",  operand, {hdr[80:16], 16'd5});
        n = 0;
        do begin step(); n++; end while (!valid_opcode && n < 20);
        chk("m_gap",    81'(n), 81'(LAT + 1));
        chk("m_oper2",  81'(operand[NW-1:0]), 81'(6));
        step(); step(); step();
        match_found = 1'b1;
        step();
        match_found = 1'b0;
        chk("m_done",   81'(done), 81'(1));
        chk("m_found",  81'(found), 81'(1));
        chk("m_fnonce", 81'(found_nonce), 81'(6));
        chk("m_att",    81'(attempts), 81'(2));
        chk("m_smine0", 81'(start_mine), 81'(0));
        step();
        chk("m_idle",   81'(job_ready), 81'(1));
        chk("m_done0",  81'(done), 81'(0));
        chk("m_hold",   81'(attempts), 81'(2));

        // Exhaustion of a 3-nonce range
        offer(8'h20, 16'd100, 16'd3);
        step();
        job_valid = 1'b0;
        run_to_done(60);
        chk("x_strobes", 81'(nstrobes), 81'(3));
        chk("x_cycles",  81'(ncycles), 81'(3 * (LAT + 1)));
        chk("x_n0",      81'(nlog[0]), 81'(100));
        chk("x_n1",      81'(nlog[1]), 81'(101));
        chk("x_n2",      81'(nlog[2]), 81'(102));
        chk("x_found",   81'(found), 81'(0));
        chk("x_att",     81'(attempts), 81'(3));
        step();

        // Nonce wrap
        offer(8'h21, 16'hFFFF, 16'd2);
        step();
        job_valid = 1'b0;
        run_to_done(40);
        chk("w_strobes", 81'(nstrobes), 81'(2));
        chk("w_n0",      81'(nlog[0]), 81'(16'hFFFF));
        chk("w_n1",      81'(nlog[1]), 81'(0));
        chk("w_att",     81'(attempts), 81'(2));
        step();

        // Abort beats match in the same WAIT cycle
        offer(8'h33, 16'd50, 16'd5);
        step();
        job_valid = 1'b0;
        step(); step(); step();
        abort       = 1'b1;
        match_found = 1'b1;
        step();
        abort       = 1'b0;
        match_found = 1'b0;
        chk("a_done",   81'(done), 81'(1));
        chk("a_found",  81'(found), 81'(0));
        chk("a_fnonce", 81'(found_nonce), 81'(6));
        chk("a_att",    81'(attempts), 81'(1));
        step();
        chk("a_idle",   81'(job_ready), 81'(1));

        // job_valid held through a busy job; match during ISSUE ignored
        offer(8'h44, 16'd200, 16'd1);
        step();
        chk("h_nA", 81'(operand[NW-1:0]), 81'(200));
        offer(8'h55, 16'd300, 16'd2);
        n = 0;
        do begin step(); n++; end while (!valid_opcode && n < 30);
        chk("h_wait", 81'(n), 81'(LAT + 3));
        chk("h_nB",   81'(operand[NW-1:0]), 81'(300));
        chk("h_opc",  81'(opcode), 81'h55);
        job_valid   = 1'b0;
        match_found = 1'b1;
        step();
        match_found = 1'b0;
        run_to_done(40);
        chk("h_strobes", 81'(nstrobes), 81'(1));
        chk("h_n1",      81'(nlog[0]), 81'(301));
        chk("h_found",   81'(found), 81'(0));
        chk("h_att",     81'(attempts), 81'(2));
        step();

        // Count 0 runs the full range: no early done over 70000 cycles
        offer(8'h66, 16'd0, 16'd0);
        step();
        job_valid = 1'b0;
        got_done  = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            step();
            got_done = got_done | done;
        end
        chk("z_nodone", 81'(got_done), 81'(0));
        chk("z_att",    81'(attempts), 81'(70000 / (LAT + 1) + 1));
        chk("z_nonce",  81'(operand[NW-1:0]), 81'(70000 / (LAT + 1)));

        // Async reset mid-WAIT
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_ready", 81'(job_ready), 81'(1));
        chk("r_busy",  81'(busy), 81'(0));
        chk("r_vop",   81'(valid_opcode), 81'(0));
        chk("r_smine", 81'(start_mine), 81'(0));
        chk("r_att",   81'(attempts), 81'(0));
        chk("r_oper",  operand, 81'(0));
        chk("r_fn",    81'(found_nonce), 81'(0));
        #10;
        rst_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mining_job_scheduler.md
Name: mining_job_scheduler

Overview:
- Sequences the mining_pipeline datapath for one mining job at a time.
- Accepts a job (opcode, 81-bit header, nonce range) over a valid/ready handshake.
- Drives the pipeline's opcode/operand/valid_opcode/start_mine inputs one nonce at a time and watches match_found inside a bounded result window.
- Reports the winning nonce, or exhaustion of the range, to the host-side job queue.

Parameters:
- NONCE_W, 16, nonce width; nonce occupies operand[NONCE_W-1:0].
- RESULT_LAT, 8, cycles after the issue cycle during which match_found is attributed to the issued nonce (≥1).
- CNT_W, 32, width of the attempts counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- job_valid  in  1  job offered.
- job_ready  out  1  scheduler can accept a job (high only in IDLE).
- job_opcode  in  8  opcode applied for every nonce of the job.
- job_header  in  81  header; upper 81-NONCE_W bits are passed to the operand.
- job_nonce_start  in  NONCE_W  first nonce.
- job_nonce_count  in  NONCE_W  number of nonces to try; 0 means 2^NONCE_W.
- abort  in  1  cancel the current job.
- opcode  out  8  to pipeline.
- operand  out  81  to pipeline: {header[80:NONCE_W], nonce}.
- valid_opcode  out  1  one-cycle issue strobe to pipeline.
- start_mine  out  1  high from the first issue until the job ends.
- match_found  in  1  from pipeline.
- busy  out  1  job in progress (not IDLE).
- done  out  1  one-cycle pulse when a job ends.
- found  out  1  on done: 1 = match, 0 = exhausted or aborted.
- found_nonce  out  NONCE_W  nonce that matched; held until the next done.
- attempts  out  CNT_W  nonces issued in the current/last job; saturates at all-ones.

Behaviour:
- Reset (async assert, sync release): state IDLE, job_ready=1, every other output 0 (opcode, operand, found_nonce, attempts included).
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Accept on job_valid&&job_ready.
  - Latch opcode, header and nonce=job_nonce_start.
  - Set remaining = count (count 0 loads 2^NONCE_W; remaining is NONCE_W+1 bits).
  - Clear attempts and found; go to ISSUE.
- ISSUE (1 cycle):
  - valid_opcode=1; opcode and operand stable from this cycle through the end of WAIT.
  - start_mine=1; attempts+=1; remaining-=1.
  - Go to WAIT; window counter loaded to RESULT_LAT.
- WAIT:
  - Counter decrements each cycle.
  - match_found=1 on any WAIT cycle: found=1, found_nonce=current nonce, go to DONE.
  - Counter expires with remaining≠0: nonce+=1 (wraps modulo 2^NONCE_W), back to ISSUE.
  - Counter expires with remaining=0: go to DONE with found=0.
  - match_found during the ISSUE cycle or in IDLE/DONE is ignored.
- DONE (1 cycle):
  - done=1; start_mine=0; valid_opcode=0; go to IDLE.
  - found/found_nonce/attempts hold until the next accept (found_nonce until the next match).
- Per-nonce cadence: exactly 1+RESULT_LAT cycles per nonce. Latency from accept to first valid_opcode is 1 cycle.
- Abort:
  - Sampled in ISSUE or WAIT; takes priority over match_found and expiry.
  - Next state DONE with found=0; the in-flight nonce is not re-issued.
  - Abort in IDLE or DONE has no effect.
- job_valid while busy: ignored (job_ready=0); the upstream must hold it.
- Reset mid-job: all outputs return to reset values immediately; no done pulse.

Test Plan:
- Reset state: rst_n=0 mid-WAIT → job_ready=1, busy=0, valid_opcode=0, start_mine=0, attempts=0 asynchronously.
- Single match: RESULT_LAT=8, opcode 8'h10, nonce_start=5, count=4, match_found pulsed 3 cycles after the 2nd valid_opcode → valid_opcode strobes 9 cycles apart, operand[15:0]=5 then 6, done with found=1, found_nonce=6, attempts=2.
- Exhaustion: count=3, no match → 3 strobes with nonces start..start+2, then done with found=0, attempts=3; total 1+3·9 cycles accept-to-done.
- Wrap and zero count: nonce_start=16'hFFFF, count=2 → nonces FFFF then 0000; with count=0, check attempts after 70000 cycles is consistent (no early done).
- Abort priority: abort and match_found asserted in the same WAIT cycle → done with found=0 next cycle, found_nonce unchanged from the previous job.
- Handshake: job_valid held through a busy job with new parameters → not accepted until IDLE, then accepted with a 1-cycle accept-to-issue; match_found in the ISSUE cycle is ignored.
